// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage program-counter controller.
//
// Produces the instruction ROM fetch address from the ID-stage branch request.
// It also handles pipeline stalls and exception flushes.
//
// Held branches: a taken branch can resolve while IF is stalled. In that case the
// target is held until the delay-slot instruction (the one at the current pc) has
// actually been fetched. Only then does the pc redirect.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   - Adds the fetch_addr_err output.
//   - A pc with pc[1:0] != 0 raises fetch_addr_err and suppresses rom_en.
//   - fetch_addr_err stays set until a flush loads an aligned pc.
//
// Parameters:
//   ADDR_WIDTH  width of the pc and of all address ports
//   RESET_PC    pc value loaded on reset
//
// Ports:
//   clk                       system clock, rising edge
//   rst                       asynchronous, active-high reset
//   stall_if                  IF hold from the pipeline controller
//   flush                     exception/eret flush; overrides everything
//   flush_pc                  flush target
//   branch_flag               taken branch from ID
//   branch_addr               branch target from ID
//   next_inst_delayslot_flag  instruction now in ID has a delay slot
//   rom_ready                 instruction memory accepted rom_addr this cycle
//   rom_en                    fetch request valid (registered)
//   rom_addr                  fetch address, equal to pc
//   pc                        current fetch pc, forwarded to IF/ID
//   in_delayslot              registered delay-slot marker for ID
//   fetch_addr_err            misaligned-pc flag (PC_ALIGN_CHECK_EN only)
//   branch_pending            a taken branch is being held

module pc_fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_if,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  next_inst_delayslot_flag,
    input  logic                  rom_ready,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  in_delayslot,
`ifdef PC_ALIGN_CHECK_EN
    output logic                  fetch_addr_err,
`endif
    output logic                  branch_pending
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic                    branch_pending_q, branch_pending_d;
    logic                    in_delayslot_q, in_delayslot_d;
    logic                    rom_en_q, rom_en_d;
    logic                    fetch_done;

    // A fetch only completes when memory takes the request and IF is free to advance.
    // Completion is also the moment the ID stage advances.
    assign fetch_done = rom_en_q & rom_ready & ~stall_if;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pend_addr_d      = pend_addr_q;
        branch_pending_d = branch_pending_q;
        in_delayslot_d   = in_delayslot_q;

        if (flush) begin
            pc_d             = flush_pc;
            branch_pending_d = 1'b0;
            in_delayslot_d   = 1'b0;
            state_d          = StRun;
        end else begin
            if (fetch_done) begin
                in_delayslot_d = next_inst_delayslot_flag;
            end
            unique case (state_q)
                StBoot: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (branch_flag) begin
                        if (fetch_done) begin
                            pc_d = branch_addr;
                        end else begin
                            // The delay slot has not been fetched yet.
                            // Park the target until it has been.
                            pend_addr_d      = branch_addr;
                            branch_pending_d = 1'b1;
                            state_d          = StHold;
                        end
                    end else if (fetch_done) begin
                        pc_d = pc_q + ADDR_WIDTH'(4);
                    end
                end
                StHold: begin
                    // ID is stalled while a branch is held.
                    // A new branch_flag here is therefore ignored.
                    if (fetch_done) begin
                        pc_d             = pend_addr_q;
                        branch_pending_d = 1'b0;
                        state_d          = StRun;
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fetch_addr_err_q, fetch_addr_err_d;

    // While misaligned, no fetch can complete, so only a flush can move pc.
    // The flag therefore tracks the alignment of pc directly.
    assign fetch_addr_err_d = |pc_d[1:0];
    assign rom_en_d         = (state_d != StBoot) & ~fetch_addr_err_d;
    assign fetch_addr_err   = fetch_addr_err_q;
`else
    assign rom_en_d         = (state_d != StBoot);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StBoot;
            pc_q             <= RESET_PC;
            pend_addr_q      <= '0;
            branch_pending_q <= 1'b0;
            in_delayslot_q   <= 1'b0;
            rom_en_q         <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fetch_addr_err_q <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pend_addr_q      <= pend_addr_d;
            branch_pending_q <= branch_pending_d;
            in_delayslot_q   <= in_delayslot_d;
            rom_en_q         <= rom_en_d;
`ifdef PC_ALIGN_CHECK_EN
            fetch_addr_err_q <= fetch_addr_err_d;
`endif
        end
    end

    assign pc             = pc_q;
    assign rom_addr       = pc_q;
    assign rom_en         = rom_en_q;
    assign in_delayslot   = in_delayslot_q;
    assign branch_pending = branch_pending_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl.
// A behavioural reference model is compared against the DUT on every falling edge.
// Literal expectations pin the model at the key points of the sequence.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        next_inst_delayslot_flag;
    logic        rom_ready;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] pc;
    logic        in_delayslot;
    logic        branch_pending;
    logic        fetch_addr_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;

    pc_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .stall_if                 (stall_if),
        .flush                    (flush),
        .flush_pc                 (flush_pc),
        .branch_flag              (branch_flag),
        .branch_addr              (branch_addr),
        .next_inst_delayslot_flag (next_inst_delayslot_flag),
        .rom_ready                (rom_ready),
        .rom_en                   (rom_en),
        .rom_addr                 (rom_addr),
        .pc                       (pc),
        .in_delayslot             (in_delayslot),
`ifdef PC_ALIGN_CHECK_EN
        .fetch_addr_err           (fetch_addr_err),
`endif
        .branch_pending           (branch_pending)
    );

`ifndef PC_ALIGN_CHECK_EN
    assign fetch_addr_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    // It tracks a pc, a "still booting" flag and an optional held branch target.
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic        m_ds;
    logic        m_en;
    logic        m_err;
    logic        m_done;

`ifdef PC_ALIGN_CHECK_EN
    assign m_err = (m_pc[1:0] != 2'b00);
`else
    assign m_err = 1'b0;
`endif
    assign m_en   = !m_boot && !m_err;
    assign m_done = m_en && rom_ready && !stall_if;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc        <= RST_PC;
            m_boot      <= 1'b1;
            m_pend      <= 1'b0;
            m_pend_addr <= 32'h0;
            m_ds        <= 1'b0;
        end else begin
            m_boot <= 1'b0;
            if (flush) begin
                m_pc   <= flush_pc;
                m_pend <= 1'b0;
                m_ds   <= 1'b0;
            end else begin
                if (m_done) m_ds <= next_inst_delayslot_flag;
                if (m_pend) begin
                    if (m_done) begin
                        m_pc   <= m_pend_addr;
                        m_pend <= 1'b0;
                    end
                end else if (!m_boot) begin
                    if (branch_flag && m_done) begin
                        m_pc <= branch_addr;
                    end else if (branch_flag) begin
                        m_pend      <= 1'b1;
                        m_pend_addr <= branch_addr;
                    end else if (m_done) begin
                        m_pc <= m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("model pc", pc, m_pc);
            chk("model rom_addr", rom_addr, m_pc);
            chk("model rom_en", {31'b0, rom_en}, {31'b0, m_en});
            chk("model in_delayslot", {31'b0, in_delayslot}, {31'b0, m_ds});
            chk("model branch_pending", {31'b0, branch_pending}, {31'b0, m_pend});
            chk("model fetch_addr_err", {31'b0, fetch_addr_err}, {31'b0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        stall_if = 1'b0;
        flush = 1'b0;
        flush_pc = 32'h0;
        branch_flag = 1'b0;
        branch_addr = 32'h0;
        next_inst_delayslot_flag = 1'b0;
        rom_ready = 1'b1;
        #1 rst = 1'b1;
        step();
        checking = 1;
        step();
        chk("reset pc", pc, RST_PC);
        chk("reset rom_en", {31'b0, rom_en}, 32'd0);
        chk("reset branch_pending", {31'b0, branch_pending}, 32'd0);
        chk("reset in_delayslot", {31'b0, in_delayslot}, 32'd0);

        // Boot: one cycle with rom_en low, then fetching starts.
        rst = 1'b0;
        #1 chk("boot rom_en low", {31'b0, rom_en}, 32'd0);
        step();
        chk("boot done rom_en", {31'b0, rom_en}, 32'd1);
        chk("boot done pc", pc, 32'hBFC00000);
        step();
        chk("pc step 1", pc, 32'hBFC00004);
        step();
        chk("pc step 2", pc, 32'hBFC00008);

        // Branch with no stall.
        branch_flag = 1'b1;
        branch_addr = 32'hBFC00100;
        next_inst_delayslot_flag = 1'b1;
        step();
        chk("branch pc", pc, 32'hBFC00100);
        chk("branch in_delayslot", {31'b0, in_delayslot}, 32'd1);
        branch_flag = 1'b0;
        next_inst_delayslot_flag = 1'b0;

        // Branch arriving during a 3-cycle stall.
        stall_if = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 32'hBFC00200;
        step();
        branch_flag = 1'b0;
        step();
        step();
        chk("stall pending", {31'b0, branch_pending}, 32'd1);
        chk("stall pc held", pc, 32'hBFC00100);
        stall_if = 1'b0;
        step();
        chk("release pc", pc, 32'hBFC00200);
        chk("release pending", {31'b0, branch_pending}, 32'd0);

        // Flush overrides a held branch.
        next_inst_delayslot_flag = 1'b1;
        step();
        chk("ds set", {31'b0, in_delayslot}, 32'd1);
        next_inst_delayslot_flag = 1'b0;
        stall_if = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 32'hBFC00200;
        step();
        branch_flag = 1'b0;
        flush = 1'b1;
        flush_pc = 32'hBFC00380;
        step();
        chk("flush pc", pc, 32'hBFC00380);
        chk("flush pending", {31'b0, branch_pending}, 32'd0);
        chk("flush in_delayslot", {31'b0, in_delayslot}, 32'd0);
        stall_if = 1'b0;

        // Wrap-around under rom_ready backpressure.
        flush_pc = 32'hFFFFFFFC;
        step();
        flush = 1'b0;
        rom_ready = 1'b0;
        step();
        step();
        chk("backpressure pc held", pc, 32'hFFFFFFFC);
        rom_ready = 1'b1;
        step();
        chk("wrap pc", pc, 32'h00000000);

        // A second branch while one is held is ignored.
        stall_if = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 32'h00000100;
        step();
        branch_addr = 32'h00000300;
        step();
        branch_flag = 1'b0;
        stall_if = 1'b0;
        step();
        chk("hold ignores second branch", pc, 32'h00000100);

        // Reset while holding drops the pending branch at once.
        stall_if = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 32'h00000500;
        step();
        branch_flag = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid-hold reset pending", {31'b0, branch_pending}, 32'd0);
        chk("mid-hold reset pc", pc, RST_PC);
        step();
        rst = 1'b0;
        stall_if = 1'b0;
        step();
        step();
        chk("after reset pc", pc, 32'hBFC00004);

        // Misaligned branch target.
        branch_flag = 1'b1;
        branch_addr = 32'hBFC00102;
        step();
        branch_flag = 1'b0;
        chk("misaligned pc", pc, 32'hBFC00102);
`ifdef PC_ALIGN_CHECK_EN
        chk("align err set", {31'b0, fetch_addr_err}, 32'd1);
        chk("align rom_en off", {31'b0, rom_en}, 32'd0);
        step();
        chk("align pc stuck", pc, 32'hBFC00102);
`else
        chk("no align check rom_en", {31'b0, rom_en}, 32'd1);
        step();
        chk("misaligned pc advances", pc, 32'hBFC00106);
`endif
        flush = 1'b1;
        flush_pc = 32'hBFC00380;
        step();
        flush = 1'b0;
        chk("realign pc", pc, 32'hBFC00380);
        chk("realign err", {31'b0, fetch_addr_err}, 32'd0);
        chk("realign rom_en", {31'b0, rom_en}, 32'd1);
        step();
        step();
        chk("final pc", pc, 32'hBFC00388);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- IF-stage program-counter controller. Consumes the ID-stage branch request (branch_flag, branch_addr, next_inst_delayslot_flag) and produces the fetch address for instruction ROM.
- Holds a branch that resolves while IF is stalled, so the delay-slot instruction is always fetched before the redirect.
- Returns a registered delay-slot marker to ID.
- Exception flush from the pipeline controller overrides everything.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- ADDR_WIDTH, 32, width of PC and all address ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_if  in  1  pipeline controller holds IF; PC must not advance.
- flush  in  1  exception/eret flush; redirect to flush_pc.
- flush_pc  in  ADDR_WIDTH  exception/eret target.
- branch_flag  in  1  branch taken, from ID.
- branch_addr  in  ADDR_WIDTH  branch target, from ID.
- next_inst_delayslot_flag  in  1  instruction now in ID has a delay slot.
- rom_ready  in  1  instruction memory accepted rom_addr this cycle.
- rom_en  out  1  fetch request valid.
- rom_addr  out  ADDR_WIDTH  fetch address (equals pc).
- pc  out  ADDR_WIDTH  current fetch PC, forwarded to IF/ID.
- in_delayslot  out  1  registered; instruction entering ID is a delay slot.
- branch_pending  out  1  debug/status; a taken branch is held.

Behaviour:
- Reset, async on rst high:
  - pc = RESET_PC, rom_en = 0, in_delayslot = 0, branch_pending = 0.
  - State = BOOT.
- States:
  - BOOT: rom_en = 0 for exactly one cycle after rst deasserts, then go to RUN. pc does not change.
  - RUN: rom_en = 1.
  - HOLD: rom_en = 1. A branch is latched in pend_addr.
- A fetch completes when rom_en & rom_ready & ~stall_if. The PC updates only on a completed fetch, or on flush.
- Next-PC priority, evaluated each cycle:
  1. flush: pc = flush_pc next cycle, in any state, regardless of stall_if or rom_ready. Clears pending. in_delayslot = 0. State = RUN.
  2. HOLD with a completed fetch: pc = pend_addr. Clear pending. State = RUN.
  3. RUN, branch_flag = 1, fetch completes in the same cycle: pc = branch_addr.
  4. RUN, branch_flag = 1, fetch does not complete: latch pend_addr = branch_addr, set branch_pending, go to HOLD. pc unchanged.
  5. RUN, completed fetch, no branch: pc = pc + 4. Unsigned wrap 32'hFFFFFFFC -> 0.
  6. Otherwise: pc holds.
- branch_flag arriving while already in HOLD is ignored; ID is stalled then by construction. pend_addr is not overwritten.
- in_delayslot:
  - Loaded with next_inst_delayslot_flag when the ID stage advances, i.e. on a completed fetch.
  - Held otherwise.
  - Cleared by flush.
- Latency: branch_flag to rom_addr = target is 1 cycle when there is no stall, and 1 cycle after the stall releases otherwise.
- rom_addr = pc combinationally. There is no additional delay.
- The low 2 bits of branch_addr and flush_pc are taken as given; there is no masking.
- rst asserted mid-HOLD drops the pending branch immediately.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_addr_err (1 bit, reset 0).
  - fetch_addr_err is asserted, registered, in the cycle pc takes a value with pc[1:0] != 0. rom_en is forced to 0 while pc is misaligned, so there is no memory access.
  - The error is held until flush loads a new pc.
- Undefined:
  - No port and no check.
  - Misaligned PCs are fetched as-is.

Test Plan:
- Reset and boot: rst 1 -> 0 -> pc = 32'hBFC00000 and rom_en = 0 for one cycle, then rom_en = 1. With rom_ready = 1, pc steps BFC00004, BFC00008.
- Branch, no stall: branch_flag = 1, branch_addr = 32'hBFC00100, next_inst_delayslot_flag = 1 at pc = BFC00008 -> next pc = BFC00100, in_delayslot = 1.
- Branch during stall: stall_if = 1 for 3 cycles with branch_flag pulsed, addr BFC00200 -> branch_pending = 1 and pc held. On stall release, the completed fetch gives pc = BFC00200 and branch_pending = 0.
- Flush vs pending: in HOLD with pend_addr = BFC00200, assert flush with flush_pc = 32'hBFC00380 and stall_if = 1 -> pc = BFC00380, branch_pending = 0, in_delayslot = 0.
- Wrap and rom_ready backpressure:
  - pc = FFFFFFFC with rom_ready = 0 for 2 cycles -> pc held.
  - Then rom_ready = 1 -> pc = 00000000.
- Alignment (with PC_ALIGN_CHECK_EN): branch_addr = BFC00102 -> fetch_addr_err = 1, rom_en = 0. Then flush to BFC00380 -> fetch_addr_err = 0, rom_en = 1.
